// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU
// with pipeline stall/flush handshake.
module div_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  alu_op,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic [31:0] result
);
    typedef enum logic [1:0] {IDLE, BUSY, SIGN, DONE} state_t;
    state_t      state_q;
    logic [4:0]  cnt_q;
    logic        rem_op_q, neg_q, qneg_q;
    logic [31:0] dvd_q, dvs_q, rem_q, result_q;
    logic        accept, sgn, a_neg, b_neg, div0, ovf, ge;
    logic [31:0] a_mag, b_mag, special, quo_d, rem_d, sign_res;
    logic [32:0] rem_sh, diff;
    assign accept   = reset & (state_q == IDLE) & start & alu_op[3] & alu_op[2] & ~flush;
    assign sgn      = ~alu_op[0];
    assign a_neg    = sgn & data1[31];
    assign b_neg    = sgn & data2[31];
    assign a_mag    = a_neg ? -data1 : data1;
    assign b_mag    = b_neg ? -data2 : data2;
    assign div0     = data2 == 32'h0;
    assign ovf      = sgn & (data1 == 32'h8000_0000) & (data2 == 32'hFFFF_FFFF);
    assign special  = alu_op[1] ? (div0 ? data1 : 32'h0) : (div0 ? 32'hFFFF_FFFF : 32'h8000_0000);
    // dvd_q shifts the dividend out and the quotient in, one bit per step
    assign rem_sh   = {rem_q, dvd_q[31]};
    assign diff     = rem_sh - {1'b0, dvs_q};
    assign ge       = ~diff[32];
    assign rem_d    = ge ? diff[31:0] : rem_sh[31:0];
    assign quo_d    = {dvd_q[30:0], ge};
    assign sign_res = rem_op_q ? (neg_q ? -rem_q : rem_q) : (qneg_q ? -dvd_q : dvd_q);
    assign stall    = (state_q == BUSY) | (state_q == SIGN) | accept;
    assign done     = state_q == DONE;
    assign result   = result_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            rem_op_q <= 1'b0;
            neg_q    <= 1'b0;
            qneg_q   <= 1'b0;
            dvd_q    <= 32'h0;
            dvs_q    <= 32'h0;
            rem_q    <= 32'h0;
            result_q <= 32'h0;
        end else if (flush) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    rem_op_q <= alu_op[1];
                    neg_q    <= a_neg;
                    qneg_q   <= a_neg ^ b_neg;
                    dvd_q    <= a_mag;
                    dvs_q    <= b_mag;
                    rem_q    <= 32'h0;
                    cnt_q    <= 5'd0;
                    if (div0 | ovf) begin
                        result_q <= special;
                        state_q  <= DONE;
                    end else begin
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    dvd_q <= quo_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= SIGN;
                end
                SIGN: begin
                    result_q <= sign_res;
                    state_q  <= DONE;
                end
                DONE: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed and random checks of div_sequencer against an
// arithmetic reference model with countdown-based timing.
module tb_div_sequencer;
    logic        clk = 1'b0, reset, start, flush, stall, done;
    logic [4:0]  alu_op;
    logic [31:0] data1, data2, result;
    int          n_chk = 0, n_fail = 0;
    int          m_rem = 0;
    bit          m_done = 0, m_sp;
    logic [31:0] m_res = 0, m_pend = 0;
    localparam logic [4:0] OP_DIV = 5'b01100, OP_DIVU = 5'b01101, OP_REM = 5'b01110, OP_REMU = 5'b01111;

    div_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .alu_op(alu_op), .data1(data1),
        .data2(data2), .flush(flush), .stall(stall), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, output bit sp);
        bit is_rem = op[1], is_s = !op[0];
        int sa = a, sb = b;
        sp = (b == 0) || (is_s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        if (b == 0) return is_rem ? a : 32'hFFFF_FFFF;
        if (sp) return is_rem ? 32'h0 : 32'h8000_0000;
        if (is_s) return is_rem ? sa % sb : sa / sb;
        return is_rem ? a % b : a / b;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_rem = 0; m_done = 0; m_res = 0;
        end else if (flush) begin
            m_rem = 0; m_done = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin m_done = 1; m_res = m_pend; end
        end else if (start && alu_op[3] && alu_op[2]) begin
            m_pend = ref_div(alu_op, data1, data2, m_sp);
            if (m_sp) begin m_done = 1; m_res = m_pend; end
            else m_rem = 33;
        end
    end

    always @(negedge clk) begin
        bit exp_stall;
        exp_stall = reset && (m_rem > 0 || (!m_done && start && alu_op[3] && alu_op[2] && !flush));
        check("stall", {31'h0, stall}, {31'h0, exp_stall});
        check("done", {31'h0, done}, {31'h0, m_done});
        check("result", result, m_res);
    end

    task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp, input int lat);
        int n = 0;
        @(posedge clk); #1;
        while ((m_rem != 0 || m_done) && n < 50) begin @(posedge clk); #1; n++; end
        start = 1; alu_op = op; data1 = a; data2 = b;
        @(posedge clk); #1;
        start = 0; data1 = $urandom; data2 = $urandom;
        n = 1;
        while (!done && n < 40) begin @(posedge clk); #1; n++; end
        check("latency", n, lat);
        check("run_result", result, exp);
    endtask

    initial begin
        bit sp;
        logic [31:0] prev;
        reset = 0; start = 0; flush = 0; alu_op = 0; data1 = 0; data2 = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1;
        check("model_divu", ref_div(OP_DIVU, 100, 7, sp), 32'd14);
        check("model_div_neg", ref_div(OP_DIV, 32'hFFFF_FFF9, 2, sp), 32'hFFFF_FFFD);
        check("model_rem_neg", ref_div(OP_REM, 32'hFFFF_FFF9, 2, sp), 32'hFFFF_FFFF);
        run(OP_DIVU, 100, 7, 32'd14, 34);
        run(OP_REMU, 100, 7, 32'd2, 34);
        run(OP_DIV, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 34);
        run(OP_REM, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 34);
        run(OP_DIV, 7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
        run(OP_DIV, 32'h1234_5678, 0, 32'hFFFF_FFFF, 1);
        run(OP_REM, 32'h1234_5678, 0, 32'h1234_5678, 1);
        run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
        @(posedge clk); #1;
        start = 1; alu_op = OP_DIVU; data1 = 1000; data2 = 3;
        @(posedge clk); #1;
        start = 0;
        repeat (10) @(posedge clk);
        #1 flush = 1; prev = result;
        @(posedge clk); #1;
        flush = 0;
        check("flush_stall", {31'h0, stall}, 32'h0);
        check("flush_done", {31'h0, done}, 32'h0);
        check("flush_result", result, prev);
        run(OP_DIVU, 100, 7, 32'd14, 34);
        @(posedge clk); #1;
        start = 1; alu_op = 5'b01000; data1 = 6; data2 = 3;
        #1 check("mul_stall", {31'h0, stall}, 32'h0);
        repeat (3) @(posedge clk);
        #1 check("mul_done", {31'h0, done}, 32'h0);
        start = 0;
        @(posedge clk); #1;
        start = 1; alu_op = OP_DIVU; data1 = 55; data2 = 5;
        @(posedge clk); #1;
        start = 0;
        repeat (5) @(posedge clk);
        #2 reset = 0;
        #1 check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_result", result, 32'h0);
        @(posedge clk); #1 reset = 1;
        run(OP_DIVU, 100, 7, 32'd14, 34);
        for (int i = 0; i < 4000; i++) begin
            logic [4:0] op;
            @(posedge clk); #1;
            op = 5'($urandom);
            if ($urandom_range(0, 9) < 7) op[3:2] = 2'b11;
            start = $urandom_range(0, 2) != 0;
            alu_op = op;
            case ($urandom_range(0, 7))
                0: data1 = 32'h8000_0000;
                1: data1 = $urandom_range(0, 200);
                default: data1 = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: data2 = 0;
                1: data2 = 32'hFFFF_FFFF;
                2: data2 = $urandom_range(1, 15);
                default: data2 = $urandom;
            endcase
            flush = $urandom_range(0, 39) == 0;
        end
        #1 start = 0; flush = 0;
        repeat (40) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL provide port clk, input, 1, single clock for the block; all state updates on rising edge.
REQ-002 SHALL provide port reset, input, 1, asynchronous active-low reset: state clears immediately when low, independent of clk.
REQ-003 SHALL provide port start, input, 1, ID/EX-stage instruction valid for issue this cycle.
REQ-004 SHALL provide port alu_op, input, 5, control-unit ALU code; bit3=1 with bit2=1 selects divide class, bits[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-005 SHALL provide port data1, input, 32, dividend operand (post-forwarding).
REQ-006 SHALL provide port data2, input, 32, divisor operand (post-forwarding).
REQ-007 SHALL provide port flush, input, 1, pipeline flush; aborts any in-flight divide.
REQ-008 SHALL provide port stall, output, 1, freezes PC/IF/ID/EX while a divide is pending.
REQ-009 SHALL provide port done, output, 1, one-cycle pulse: result valid.
REQ-010 SHALL provide port result, output, 32, quotient or remainder per latched op.

Function
REQ-011 SHALL implement states IDLE, BUSY, SIGN, DONE; reset state IDLE.
REQ-012 SHALL accept an op only in IDLE when start=1, alu_op[3]=1, alu_op[2]=1, flush=0; all other alu_op values ignored, no state change.
REQ-013 SHALL latch op, operand signs, and operand magnitudes on accept; signed ops (DIV, REM) take two's-complement magnitude; unsigned ops take raw values.
REQ-014 SHALL detect divisor==0 on accept: go directly to DONE; quotient 0xFFFFFFFF, remainder = data1 unmodified.
REQ-015 SHALL detect signed overflow (DIV/REM, data1=0x80000000, data2=0xFFFFFFFF) on accept: go directly to DONE; quotient 0x80000000, remainder 0.
REQ-016 Otherwise SHALL enter BUSY with 5-bit counter=0; perform one radix-2 restoring step per cycle (33-bit partial remainder subtract, quotient bit shift-in).
REQ-017 SHALL leave BUSY after exactly 32 steps (counter 31 -> wrap) to SIGN.
REQ-018 SIGN SHALL negate quotient when signed op and operand signs differ; negate remainder when signed op and dividend negative; register selected value to result; next state DONE.
REQ-019 Latency: normal op accepted at edge T -> done high in cycle after edge T+34; special cases -> done high in cycle after edge T+1.
REQ-020 DONE SHALL last exactly one cycle, then IDLE; start in DONE is ignored (instruction re-presents in IDLE).
REQ-021 stall SHALL be combinational: 1 in BUSY or SIGN, or in IDLE when an acceptable divide start is present and flush=0; 0 in DONE and otherwise.
REQ-022 result SHALL hold its value from DONE until the next DONE; unchanged by flush or ignored starts.
REQ-023 flush=1 SHALL return to IDLE on next edge from any state, suppress done, clear counter; flush has priority over start.
REQ-024 Operand inputs SHALL be don't-care after accept; changes during BUSY do not affect result.

Reset
REQ-025 While reset=0: state IDLE, counter 0, result 0x00000000, done 0, stall 0, internal operand/remainder registers 0.
REQ-026 Reset asserted mid-operation SHALL abort without done; first edge after release accepts a new op normally.

Verification
REQ-027 DIVU data1=100, data2=7 accepted at edge T -> stall high T..T+33, done pulse after T+34, result=14; REMU same operands -> 2.
REQ-028 DIV data1=-7 (0xFFFFFFF9), data2=2 -> result 0xFFFFFFFD (-3); REM same -> 0xFFFFFFFF (-1); DIV 7/-2 -> 0xFFFFFFFD.
REQ-029 DIV data2=0, data1=0x12345678 -> done after 1 edge, result 0xFFFFFFFF; REM same -> 0x12345678.
REQ-030 DIV 0x80000000 / 0xFFFFFFFF -> done after 1 edge, result 0x80000000; REM -> 0x00000000.
REQ-031 flush at counter=10 -> IDLE next edge, no done, result unchanged, stall low; back-to-back DIVU issued in following IDLE completes correctly.
REQ-032 reset low asynchronously mid-BUSY -> outputs to reset values without clock edge; non-divide alu_op (e.g. 5'b01000 MUL) with start=1 -> stall 0, no state change.
